// File: rtl/chan_512_bin_loader_pkg.sv
// Shared constants, opcodes and FSM encoding for the channelizer bin-select loader.
package chan_512_bin_pkg;

  localparam int N_CH   = 256;
  localparam int ADDR_W = 8;
  localparam int BIN_W  = 9;

  localparam int STROBE_BIT = 31;
  localparam int OP_HI      = 30;
  localparam int OP_LO      = 28;

  localparam logic [2:0] OP_WRITE = 3'd0;
  localparam logic [2:0] OP_FILL  = 3'd1;
  localparam logic [2:0] OP_SWAP  = 3'd2;

  localparam int STAT_BUSY_BIT = 31;
  localparam int STAT_SWAP_BIT = 30;
  localparam int STAT_BANK_BIT = 29;
  localparam int STAT_DROP_LO  = 16;
  localparam int STAT_WR_LO    = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_FILL,
    ST_SWAP_WAIT
  } state_e;

  function automatic logic [31:0] pack_status(input logic busy, input logic swap_pending,
                                              input logic bank_sel, input logic [7:0] drop_cnt,
                                              input logic [15:0] wr_cnt);
    return {busy, swap_pending, bank_sel, 5'b0, drop_cnt, wr_cnt};
  endfunction

endpackage

// File: rtl/chan_512_bin_loader_if.sv
// Software command / table RAM / status bundle between the loader and its surroundings.
interface chan_512_bin_loader_if;
  import chan_512_bin_pkg::*;

  logic [31:0]       load_bins;
  logic              sync_in;
  logic              tbl_we;
  logic [ADDR_W:0]   tbl_addr;
  logic [BIN_W-1:0]  tbl_data;
  logic              bank_sel;
  logic              busy;
  logic [31:0]       status;

  modport slave (
    input  load_bins, sync_in,
    output tbl_we, tbl_addr, tbl_data, bank_sel, busy, status
  );

  modport master (
    output load_bins, sync_in,
    input  tbl_we, tbl_addr, tbl_data, bank_sel, busy, status
  );

endinterface

// File: rtl/chan_512_bin_cmd_edge.sv
// Strobe rising-edge detect and capture of the address/bin fields of the accepted word.
module chan_512_bin_cmd_edge
  import chan_512_bin_pkg::*;
(
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       load_bins,
  output logic              strobe_edge,
  output logic [2:0]        opcode,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [BIN_W-1:0]  cmd_bin
);

  logic                    strobe_hist;
  logic [ADDR_W+BIN_W-1:0] cmd_word;
  logic                    unused_bits;

  assign unused_bits = ^load_bins[OP_LO-1:ADDR_W+BIN_W];
  assign strobe_edge = load_bins[STROBE_BIT] & ~strobe_hist;
  assign opcode      = load_bins[OP_HI:OP_LO];
  assign cmd_addr    = cmd_word[ADDR_W+BIN_W-1:BIN_W];
  assign cmd_bin     = cmd_word[BIN_W-1:0];

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      strobe_hist <= 1'b0;
      cmd_word    <= '0;
    end else begin
      strobe_hist <= load_bins[STROBE_BIT];
      if (strobe_edge) cmd_word <= load_bins[ADDR_W+BIN_W-1:0];
    end
  end

endmodule

// File: rtl/chan_512_bin_loader.sv
// Bin-select table sequencer: single writes and identity fill into the shadow bank,
// bank swap deferred to frame sync, drop/write counters reported in status.
module chan_512_bin_loader
  import chan_512_bin_pkg::*;
(
  input  logic                 user_clk,
  input  logic                 user_rst,
  chan_512_bin_loader_if.slave bus
);

  state_e            state, state_nxt;
  logic              strobe_edge;
  logic [2:0]        opcode;
  logic [ADDR_W-1:0] cmd_addr;
  logic [BIN_W-1:0]  cmd_bin;
  logic [ADDR_W-1:0] fill_rem;
  logic [ADDR_W-1:0] fill_idx;
  logic [ADDR_W-1:0] addr_lo;
  logic [7:0]        drop_cnt;
  logic [15:0]       wr_cnt;
  logic              bank_sel;
  logic              tbl_we;
  logic [BIN_W-1:0]  tbl_data;
  logic              busy;
  logic              swap_pending;
  logic              legal_op;
  logic              drop_evt;

  chan_512_bin_cmd_edge u_cmd_edge (
    .user_clk    (user_clk),
    .user_rst    (user_rst),
    .load_bins   (bus.load_bins),
    .strobe_edge (strobe_edge),
    .opcode      (opcode),
    .cmd_addr    (cmd_addr),
    .cmd_bin     (cmd_bin)
  );

  assign legal_op = (opcode == OP_WRITE) || (opcode == OP_FILL) || (opcode == OP_SWAP);
  assign drop_evt = strobe_edge && ((state != ST_IDLE) || !legal_op);
  // Fill counts down to a terminal zero; N_CH is a power of two so ~remaining is the ascending index.
  assign fill_idx = ~fill_rem;

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (strobe_edge) begin
          if (opcode == OP_WRITE)     state_nxt = ST_WRITE;
          else if (opcode == OP_FILL) state_nxt = ST_FILL;
          else if (opcode == OP_SWAP) state_nxt = ST_SWAP_WAIT;
        end
      end
      ST_WRITE:     state_nxt = ST_IDLE;
      ST_FILL:      if (fill_rem == '0) state_nxt = ST_IDLE;
      ST_SWAP_WAIT: if (bus.sync_in) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    tbl_we       = 1'b0;
    addr_lo      = '0;
    tbl_data     = '0;
    busy         = (state != ST_IDLE);
    swap_pending = (state == ST_SWAP_WAIT);
    case (state)
      ST_WRITE: begin
        tbl_we   = 1'b1;
        addr_lo  = cmd_addr;
        tbl_data = cmd_bin;
      end
      ST_FILL: begin
        tbl_we   = 1'b1;
        addr_lo  = fill_idx;
        tbl_data = {{(BIN_W-ADDR_W){1'b0}}, fill_idx};
      end
      default: ;
    endcase
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      fill_rem <= ADDR_W'(N_CH-1);
      bank_sel <= 1'b0;
      drop_cnt <= '0;
      wr_cnt   <= '0;
    end else begin
      if (state == ST_FILL) fill_rem <= fill_rem - 1'b1;
      else                  fill_rem <= ADDR_W'(N_CH-1);
      if (state == ST_SWAP_WAIT && bus.sync_in) bank_sel <= ~bank_sel;
      if (drop_evt && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (tbl_we) wr_cnt <= wr_cnt + 16'd1;
    end
  end

  assign bus.tbl_we   = tbl_we;
  assign bus.tbl_addr = {~bank_sel, addr_lo};
  assign bus.tbl_data = tbl_data;
  assign bus.bank_sel = bank_sel;
  assign bus.busy     = busy;
  assign bus.status   = pack_status(busy, swap_pending, bank_sel, drop_cnt, wr_cnt);

endmodule
